sha256_round_engine: RTL and testbench
======================================

Name: sha256_round_engine

Overview:
- Iterative SHA-256/SHA-224 compression engine. Successor to the single-cycle Σ/σ/Ch/Maj operator unit.
- Holds the chaining state H0..H7 and the 16-word message-schedule window internally.
- Runs all 64 rounds on a 512-bit block under a valid/ready handshake.
- Sits beside the core as a memory-mapped or streaming hash coprocessor. Round count per cycle is parametrised.

Parameters:
- ROUNDS_PER_CYCLE, 1, compression rounds evaluated per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- SUPPORT_SHA224, 1, when 0 mode_i is ignored and the SHA-256 IV is always used.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- init_i  input  1  start new message: reload IV selected by mode_i
- mode_i  input  1  0 = SHA-256 IV, 1 = SHA-224 IV; sampled only when init_i is accepted
- blk_valid_i  input  1  512-bit padded block present
- blk_ready_o  output  1  engine can accept a block
- blk_data_i  input  512  block; W0 = [511:480] … W15 = [31:0], big-endian words
- busy_o  output  1  compression in progress
- digest_valid_o  output  1  digest_o holds result of last completed block
- digest_o  output  256  {H0..H7}; SHA-224 users take [255:32]

Behaviour:
- Reset is asynchronous and active-low:
  - state = IDLE; H0..H7 = SHA-256 IV (6a09e667 … 5be0cd19).
  - a..h and W window = 0; blk_ready_o = 1; busy_o = 0; digest_valid_o = 0.
  - digest_o always reflects the H registers, so after reset it reads the SHA-256 IV.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - blk_ready_o = 1.
  - init_i=1 loads H from the IV selected by mode_i, or the SHA-256 IV if SUPPORT_SHA224=0, and clears digest_valid_o.
  - Block acceptance is blk_valid_i & blk_ready_o. On acceptance: a..h ← H (or ← IV if init_i is asserted the same cycle), W window ← blk_data_i, round counter t ← 0, digest_valid_o ← 0, go to ROUND.
- ROUND:
  - blk_ready_o = 0, busy_o = 1.
  - Each cycle applies ROUNDS_PER_CYCLE standard rounds (T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+W[t], T2 = Σ0(a)+Maj(a,b,c)).
  - t advances by ROUNDS_PER_CYCLE per cycle.
  - For t ≥ 16, W[t] = σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16]; the window shifts one word per round.
  - All additions are mod 2^32 with carries discarded.
  - K[0..63] is an internal constant table.
  - When t reaches 64 − ROUNDS_PER_CYCLE, go to FINAL on the next edge.
- FINAL (one cycle): Hi ← Hi + {a..h}i mod 2^32; digest_valid_o ← 1; go to IDLE.
- Latency: acceptance edge → digest_valid_o high after 64/ROUNDS_PER_CYCLE + 1 cycles (65 for R=1, 33 for R=2, 17 for R=4). Throughput is one block per latency + 1 cycles.
- digest_valid_o stays 1 until the next accepted block, the next init_i, or reset.
- Multi-block messages: hold init_i low between blocks; H chains automatically.
- init_i while busy_o=1 is ignored, with no effect on the current block or on H.
- blk_valid_i held while blk_ready_o=0: the block is not consumed. The source must keep blk_data_i stable until the handshake.
- rst_ni asserted mid-ROUND or in FINAL aborts immediately to the reset state; no partial H update.
- mode_i changing without init_i has no effect.

Test Plan:
- SHA-256 "abc": init_i=1, mode_i=0, with block 61626380 00000000×14 00000018 → after 65 cycles (R=1) digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad and digest_valid_o=1.
- SHA-224 "abc": init_i=1, mode_i=1, same block → digest_o[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Send block 1 with init_i=1, then block 2 with init_i=0.
  - Final digest_o = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - digest_valid_o drops when block 2 is accepted.
- Repeat the "abc" case with ROUNDS_PER_CYCLE=2 and 4 → identical digest, with digest_valid_o at cycle 33 and 17 respectively.
- Back-pressure:
  - Hold blk_valid_i=1 with a second block throughout busy → blk_ready_o=0 for exactly 64/R+1 cycles.
  - The second block is accepted in the first IDLE cycle.
  - Pulsing init_i mid-ROUND leaves the digest unchanged.
- Reset mid-operation: deassert rst_ni at round 30 → outputs go immediately to blk_ready_o=1, busy_o=0, digest_valid_o=0, digest_o = SHA-256 IV. A following "abc" run still yields the correct digest.

Source files
------------

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256/SHA-224 compression engine: chaining state, 16-word schedule
// window and ROUNDS_PER_CYCLE unrolled rounds per clock behind a valid/ready handshake.

module sha256_round (
    input  logic [31:0]       i_k,
    input  logic [7:0][31:0]  i_st,   // [7]=a ... [0]=h
    input  logic [15:0][31:0] i_win,  // [15]=W[t] ... [0]=W[t+15]
    output logic [7:0][31:0]  o_st,
    output logic [15:0][31:0] o_win
);
    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_bsig0, w_bsig1, w_ch, w_maj, w_t1, w_t2;
    logic [31:0] w_ssig0, w_ssig1, w_wnew;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_st;

    assign w_bsig1 = rotr(w_e, 6) ^ rotr(w_e, 11) ^ rotr(w_e, 25);
    assign w_bsig0 = rotr(w_a, 2) ^ rotr(w_a, 13) ^ rotr(w_a, 22);
    assign w_ch    = (w_e & w_f) ^ (~w_e & w_g);
    assign w_maj   = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    assign w_t1    = w_h + w_bsig1 + w_ch + i_k + i_win[15];
    assign w_t2    = w_bsig0 + w_maj;

    assign o_st = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

    // W[t+16] from W[t+14], W[t+9], W[t+1], W[t]; computed every round, only
    // consumed once t >= 16 is reached.
    assign w_ssig1 = rotr(i_win[1], 17) ^ rotr(i_win[1], 19) ^ (i_win[1] >> 10);
    assign w_ssig0 = rotr(i_win[14], 7) ^ rotr(i_win[14], 18) ^ (i_win[14] >> 3);
    assign w_wnew  = w_ssig1 + i_win[6] + w_ssig0 + i_win[15];
    assign o_win   = {i_win[14:0], w_wnew};
endmodule

module sha256_round_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit SUPPORT_SHA224   = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         init_i,
    input  logic         mode_i,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] blk_data_i,
    output logic         busy_o,
    output logic         digest_valid_o,
    output logic [255:0] digest_o
);
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
        $error("sha256_round_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [7:0][31:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [7:0][31:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

    state_t            r_state;
    logic [7:0][31:0]  r_h;    // [7]=H0 so digest_o is a plain copy
    logic [7:0][31:0]  r_wk;   // working a..h
    logic [15:0][31:0] r_w;
    logic [5:0]        r_t;
    logic              r_ready, r_busy, r_dvalid;

    logic [7:0][31:0]  w_iv;
    logic [ROUNDS_PER_CYCLE:0][7:0][31:0]  w_st;
    logic [ROUNDS_PER_CYCLE:0][15:0][31:0] w_win;

    assign w_iv = (SUPPORT_SHA224 && mode_i) ? IV224 : IV256;

    assign w_st[0]  = r_wk;
    assign w_win[0] = r_w;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        logic [5:0] w_kidx;
        assign w_kidx = r_t + 6'(g);
        sha256_round u_round (
            .i_k   (K[w_kidx]),
            .i_st  (w_st[g]),
            .i_win (w_win[g]),
            .o_st  (w_st[g+1]),
            .o_win (w_win[g+1])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_h      <= IV256;
            r_wk     <= '0;
            r_w      <= '0;
            r_t      <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init_i) begin
                        r_h      <= w_iv;
                        r_dvalid <= 1'b0;
                    end
                    if (blk_valid_i && r_ready) begin
                        // Same-cycle init: start from the IV, not the stale H.
                        r_wk     <= init_i ? w_iv : r_h;
                        r_w      <= blk_data_i;
                        r_t      <= '0;
                        r_dvalid <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_wk <= w_st[ROUNDS_PER_CYCLE];
                    r_w  <= w_win[ROUNDS_PER_CYCLE];
                    r_t  <= r_t + 6'(ROUNDS_PER_CYCLE);
                    if (r_t == 6'(64 - ROUNDS_PER_CYCLE))
                        r_state <= S_FINAL;
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++)
                        r_h[i] <= r_h[i] + r_wk[i];
                    r_dvalid <= 1'b1;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign blk_ready_o    = r_ready;
    assign busy_o         = r_busy;
    assign digest_valid_o = r_dvalid;
    assign digest_o       = r_h;
endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: three instances (1, 2, 4 rounds/cycle) checked
// against known-answer vectors and a plain-arithmetic SHA-256 compression model.

module tb_sha256_round_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, init, mode;
    logic [2:0]   vld;
    logic [511:0] data;
    logic [2:0]   rdy, busy, dv;
    logic [2:0][255:0] dig;

    int n_cmp = 0;
    int n_bad = 0;

    sha256_round_engine #(.ROUNDS_PER_CYCLE(1), .SUPPORT_SHA224(1)) u_dut_r1 (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .mode_i(mode),
        .blk_valid_i(vld[0]), .blk_ready_o(rdy[0]), .blk_data_i(data),
        .busy_o(busy[0]), .digest_valid_o(dv[0]), .digest_o(dig[0]));
    sha256_round_engine #(.ROUNDS_PER_CYCLE(2), .SUPPORT_SHA224(1)) u_dut_r2 (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .mode_i(mode),
        .blk_valid_i(vld[1]), .blk_ready_o(rdy[1]), .blk_data_i(data),
        .busy_o(busy[1]), .digest_valid_o(dv[1]), .digest_o(dig[1]));
    sha256_round_engine #(.ROUNDS_PER_CYCLE(4), .SUPPORT_SHA224(1)) u_dut_r4 (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .mode_i(mode),
        .blk_valid_i(vld[2]), .blk_ready_o(rdy[2]), .blk_data_i(data),
        .busy_o(busy[2]), .digest_valid_o(dv[2]), .digest_o(dig[2]));

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] ABC256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [223:0] ABC224 =
        224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7;
    localparam logic [255:0] TWO256 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_TWO1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2 = {480'h0, 32'h000001c0};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-entry schedule, then 64 rounds, then add.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic accept(input int d, input logic [511:0] blk, input logic ini, input logic md);
        int n;
        n = 0;
        data = blk; init = ini; mode = md; vld[d] = 1'b1;
        while (!rdy[d] && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        vld[d] = 1'b0; init = 1'b0;
    endtask

    task automatic wait_dv(input int d, output int cyc);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!dv[d] && cyc < 200);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init = 1'b0; mode = 1'b0; vld = '0; data = '0;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rdy[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
        n_cmp++; if (dv[0] !== 1'b0) begin n_bad++; $display("FAIL reset_dvalid: got %b want 0", dv[0]); end
        for (int d = 0; d < 3; d++) begin
            n_cmp++; if (dig[d] !== IV256) begin n_bad++; $display("FAIL reset_digest[%0d]: got %h want %h", d, dig[d], IV256); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abc256();
        int c;
        accept(0, BLK_ABC, 1'b1, 1'b0);
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL abc_busy: got %b want 1", busy[0]); end
        wait_dv(0, c);
        n_cmp++; if (c !== 65) begin n_bad++; $display("FAIL abc_latency: got %0d want 65", c); end
        n_cmp++; if (dig[0] !== ABC256) begin n_bad++; $display("FAIL abc_digest: got %h want %h", dig[0], ABC256); end
        n_cmp++; if (dig[0] !== compress(IV256, BLK_ABC)) begin n_bad++; $display("FAIL abc_model: got %h", dig[0]); end
        n_cmp++; if ({rdy[0], busy[0]} !== 2'b10) begin n_bad++; $display("FAIL abc_idle: got %b want 10", {rdy[0], busy[0]}); end
    endtask

    task automatic test_abc224();
        int c;
        accept(0, BLK_ABC, 1'b1, 1'b1);
        wait_dv(0, c);
        n_cmp++; if (dig[0][255:32] !== ABC224) begin n_bad++; $display("FAIL abc224_digest: got %h want %h", dig[0][255:32], ABC224); end
    endtask

    task automatic test_two_block();
        int c;
        logic [255:0] h1;
        accept(0, BLK_TWO1, 1'b1, 1'b0);
        wait_dv(0, c);
        h1 = compress(IV256, BLK_TWO1);
        n_cmp++; if (dig[0] !== h1) begin n_bad++; $display("FAIL two_mid: got %h want %h", dig[0], h1); end
        accept(0, BLK_TWO2, 1'b0, 1'b1);
        n_cmp++; if (dv[0] !== 1'b0) begin n_bad++; $display("FAIL two_dv_drop: got %b want 0", dv[0]); end
        wait_dv(0, c);
        n_cmp++; if (dig[0] !== TWO256) begin n_bad++; $display("FAIL two_digest: got %h want %h", dig[0], TWO256); end
    endtask

    task automatic test_rounds_per_cycle();
        int c;
        for (int d = 1; d < 3; d++) begin
            accept(d, BLK_ABC, 1'b1, 1'b0);
            wait_dv(d, c);
            n_cmp++; if (c !== 64 / (1 << d) + 1) begin n_bad++; $display("FAIL rpc%0d_latency: got %0d want %0d", 1 << d, c, 64 / (1 << d) + 1); end
            n_cmp++; if (dig[d] !== ABC256) begin n_bad++; $display("FAIL rpc%0d_digest: got %h want %h", 1 << d, dig[d], ABC256); end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [511:0] blk_b;
        blk_b = rand_block();
        data = BLK_ABC; init = 1'b1; mode = 1'b0; vld[0] = 1'b1;
        @(posedge clk); #1;
        init = 1'b0; data = blk_b;
        c = 0;
        while (!rdy[0] && c < 200) begin
            @(posedge clk); #1; c++;
            if (c == 20) begin init = 1'b1; mode = 1'b1; end
            if (c == 21) begin init = 1'b0; mode = 1'b0; end
        end
        n_cmp++; if (c !== 65) begin n_bad++; $display("FAIL b2b_ready_low: got %0d want 65", c); end
        n_cmp++; if (dig[0] !== ABC256) begin n_bad++; $display("FAIL b2b_first: got %h want %h", dig[0], ABC256); end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        n_cmp++; if ({dv[0], busy[0]} !== 2'b01) begin n_bad++; $display("FAIL b2b_second_accept: got %b want 01", {dv[0], busy[0]}); end
        wait_dv(0, c);
        n_cmp++; if (dig[0] !== compress(ABC256, blk_b)) begin n_bad++; $display("FAIL b2b_second: got %h want %h", dig[0], compress(ABC256, blk_b)); end
    endtask

    task automatic test_reset_mid();
        int c;
        accept(0, BLK_ABC, 1'b1, 1'b0);
        repeat (29) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({rdy[0], busy[0], dv[0]} !== 3'b100) begin n_bad++; $display("FAIL rstmid_ctrl: got %b want 100", {rdy[0], busy[0], dv[0]}); end
        n_cmp++; if (dig[0] !== IV256) begin n_bad++; $display("FAIL rstmid_digest: got %h want %h", dig[0], IV256); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        accept(0, BLK_ABC, 1'b1, 1'b0);
        wait_dv(0, c);
        n_cmp++; if (dig[0] !== ABC256) begin n_bad++; $display("FAIL rstmid_rerun: got %h want %h", dig[0], ABC256); end
    endtask

    task automatic test_random();
        int c, d, nb;
        logic md;
        logic [255:0] h;
        logic [511:0] blk;
        for (int m = 0; m < 6; m++) begin
            d  = m % 3;
            md = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            h  = md ? IV224 : IV256;
            for (int b = 0; b < nb; b++) begin
                blk = rand_block();
                // Later blocks flip mode without init; it must not matter.
                accept(d, blk, b == 0, (b == 0) ? md : ~md);
                wait_dv(d, c);
                h = compress(h, blk);
                n_cmp++; if (dig[d] !== h) begin n_bad++; $display("FAIL rand_m%0d_b%0d: got %h want %h", m, b, dig[d], h); end
                n_cmp++; if (c !== 64 / (1 << d) + 1) begin n_bad++; $display("FAIL rand_lat_m%0d_b%0d: got %0d want %0d", m, b, c, 64 / (1 << d) + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_abc256();
        test_abc224();
        test_two_block();
        test_rounds_per_cycle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
